keycode_display_queue: RTL
==========================

Name: keycode_display_queue

Overview:
- Downstream consumer of the sound-box keycode output (latest_keycode / latest_keycode_valid).
- Queues every keypress and then shows each one on the board LEDs for a fixed hold time, so fast bursts are no longer lost.
- When nothing is queued, the LEDs show the sound-box debug bits.
- Replaces the ad-hoc LED counter logic in the top level. The top level keeps only the active-low inversion to the pins.

Parameters:
- CODE_W, 16: keycode width.
- DEPTH, 8: queue entries; must be a power of 2, ≥2.
- HOLD_CYCLES, 27000000: clk cycles each keycode stays displayed (1 s at 27 MHz).
- IDLE_CYCLES, 6750000: clk cycles between idle-pattern refreshes.

Ports:
- clk, in, 1: 27 MHz system clock.
- hw_reset, in, 1: asynchronous, active-high reset.
- keycode_in, in, CODE_W: keycode from the sound box.
- keycode_valid, in, 1: level, high while keycode_in is valid.
- idle_debug, in, 3: debug bits shown while idle.
- clear_overflow, in, 1: single-cycle pulse, clears overflow.
- led_buf, out, 6: active-high LED image; the top level inverts it to the pins.
- display_code, out, CODE_W: full keycode currently shown.
- showing, out, 1: high while a keycode is being displayed.
- fifo_count, out, log2(DEPTH)+1: current queue occupancy.
- overflow, out, 1: sticky; set when a keycode is dropped.

Behaviour:
- Reset values (asynchronous, all registers):
  - led_buf = 6'b110011 (power-on pattern)
  - display_code = 0, showing = 0, fifo_count = 0, overflow = 0
  - edge register = 0, state = IDLE, idle timer = IDLE_CYCLES-1, hold timer = 0
  - The power-on pattern therefore persists for one idle period.
- Capture: a push occurs on any clk edge where keycode_valid=1 and either:
  - the registered previous valid is 0 (rising edge), or
  - keycode_in differs from the last value pushed during this same valid-high interval.
  - A valid held high with a constant code pushes exactly once.
- Queue:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits, wrapping at DEPTH.
  - Push while full and no pop that cycle: data dropped, overflow set. Pointers and count unchanged.
  - Push and pop in the same cycle while full: both accepted, count stays DEPTH.
  - Push and pop in the same cycle while empty: impossible, because pop requires count>0 at that edge.
  - overflow clears on clear_overflow. If set and clear happen in the same cycle, set wins.
- FSM state IDLE:
  - showing=0, led_buf[5]=0.
  - Idle timer decrements each cycle. At 0: led_buf[2:0] <= idle_debug, timer reloads to IDLE_CYCLES-1. led_buf[4:3] hold.
  - If count>0 at an edge: pop, display_code <= entry, led_buf <= {1, entry[4:0]}, showing <= 1, hold timer <= HOLD_CYCLES-1, go to SHOW. This takes priority over the idle refresh.
- FSM state SHOW:
  - Hold timer decrements each cycle.
  - At 0 with count>0: pop the next entry the same edge (as above) and restart the hold timer. No idle gap between entries.
  - At 0 with count=0: go to IDLE, led_buf[5] <= 0, led_buf[2:0] <= idle_debug immediately, idle timer <= IDLE_CYCLES-1, showing <= 0. display_code holds its last value.
- Latency: valid rises (sampled at edge N) → entry written at N, fifo_count=1 after N → popped at edge N+1 → led_buf/display_code updated after N+1. A code is never shown for fewer than HOLD_CYCLES cycles.
- Reset asserted mid-operation discards the queue and display immediately. Outputs return to reset values asynchronously.
- Timers are 32-bit unsigned. HOLD_CYCLES and IDLE_CYCLES must be ≥1.

Test Plan (simulation with HOLD_CYCLES=10, IDLE_CYCLES=4, DEPTH=4):
- Reset release, no input → led_buf=6'b110011 for 4 cycles, then led_buf[2:0]=idle_debug (drive 3'b101) with bit5=0; refreshes every 4 cycles.
- One pulse, keycode_in=16'h0026, valid held high 20 cycles → exactly one push; two edges after the rise led_buf=6'b100110, display_code=16'h0026, showing=1 for exactly 10 cycles, then led_buf[5]=0 and [2:0]=idle_debug.
- Three 1-cycle pulses with codes 0x11, 0x12, 0x13 two cycles apart → each shown for 10 cycles back to back (led_buf[4:0]=5'h11, 5'h12, 5'h13), no idle cycle between them, fifo_count peaks at 2.
- Seven pulses during one hold period (codes 1..7, first one popped immediately) → codes 1..5 displayed, codes 6 and 7 dropped, overflow=1. A clear_overflow pulse coinciding with a further drop leaves overflow=1; a later clear with no drop gives overflow=0.
- Valid held high while the code changes 0x20 → 0x21 → 0x21 → two pushes (0x20, 0x21) only.
- Assert hw_reset midway through SHOW with 2 entries queued → outputs return to reset values in the same cycle with no clock edge needed, fifo_count=0, and nothing is displayed after release.

Source files
------------

// File: rtl/keycode_display_queue.sv
// Queues sound-box keypresses and shows each one on the board LEDs for a fixed hold time.
// When the queue is empty, the LEDs fall back to the sound-box debug bits.
`timescale 1ns/1ps
module keycode_display_queue #(
  parameter int          CODE_W      = 16,
  parameter int          DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 27000000,
  parameter int unsigned IDLE_CYCLES = 6750000
) (
  input  logic                   clk,
  input  logic                   hw_reset,
  input  logic [CODE_W-1:0]      keycode_in,
  input  logic                   keycode_valid,
  input  logic [2:0]             idle_debug,
  input  logic                   clear_overflow,
  output logic [5:0]             led_buf,
  output logic [CODE_W-1:0]      display_code,
  output logic                   showing,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] HOLD_RELOAD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] IDLE_RELOAD = 32'(IDLE_CYCLES - 1);
  localparam logic [5:0]  POWER_ON    = 6'b110011;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t              state;
  state_t              state_next;
  logic                prev_valid;
  logic [CODE_W-1:0]   last_code;
  logic                push;
  logic                pop;
  logic                to_idle;
  logic                accept;
  logic                drop;
  logic                full;
  logic                has_data;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CODE_W-1:0]   mem [DEPTH];
  logic [CODE_W-1:0]   head;
  logic [31:0]         hold_timer;
  logic [31:0]         idle_timer;

  // A held valid pushes once, plus again whenever the code changes while still held.
  assign push     = keycode_valid && (!prev_valid || (keycode_in != last_code));
  assign full     = (fifo_count == (AW+1)'(DEPTH));
  assign has_data = (fifo_count != '0);
  assign accept   = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge hw_reset) begin
    if (hw_reset) begin
      prev_valid <= 1'b0;
      last_code  <= '0;
    end else begin
      prev_valid <= keycode_valid;
      if (push) begin
        last_code <= keycode_in;
      end
    end
  end

  always_ff @(posedge clk or posedge hw_reset) begin
    if (hw_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem[wr_ptr] <= keycode_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge hw_reset) begin
    if (hw_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    to_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (has_data) begin
          pop        = 1'b1;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (hold_timer == '0) begin
          if (has_data) begin
            pop = 1'b1;
          end else begin
            to_idle    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Popping a new entry outranks both the idle refresh and the return to idle.
  always_ff @(posedge clk or posedge hw_reset) begin
    if (hw_reset) begin
      led_buf      <= POWER_ON;
      display_code <= '0;
      showing      <= 1'b0;
      hold_timer   <= '0;
      idle_timer   <= IDLE_RELOAD;
    end else if (pop) begin
      display_code <= head;
      led_buf      <= {1'b1, head[4:0]};
      showing      <= 1'b1;
      hold_timer   <= HOLD_RELOAD;
    end else if (to_idle) begin
      led_buf[5]   <= 1'b0;
      led_buf[2:0] <= idle_debug;
      showing      <= 1'b0;
      idle_timer   <= IDLE_RELOAD;
    end else if (state == SHOW) begin
      hold_timer <= hold_timer - 32'd1;
    end else if (idle_timer == '0) begin
      led_buf[5]   <= 1'b0;
      led_buf[2:0] <= idle_debug;
      idle_timer   <= IDLE_RELOAD;
    end else begin
      idle_timer <= idle_timer - 32'd1;
    end
  end

endmodule
